// File: rtl/pong_game_sequencer.sv
// Pong game sequencer: serve / rally / point / game-over control, ball step
// cadence, speed levels, scores and timer gating.
// Optional build macro PONG_SEQ_PAUSE_EN adds a level-sensitive pause input.
module pong_game_sequencer #(
  parameter int TICK_DIV    = 250000,
  parameter int SPEED_MAX   = 3,
  parameter int WIN_SCORE   = 5,
  parameter int SERVE_TICKS = 50,
  parameter int LVL_SECS    = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       sec_tick,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       ball_step,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] speed_lvl,
  output logic       timer_en,
  output logic       game_over,
  output logic       winner,
  output logic [2:0] state
`ifdef PONG_SEQ_PAUSE_EN
  ,
  input  logic       pause
`endif
);

  localparam int DIV_W = $clog2(TICK_DIV + 1);
  localparam int SRV_W = $clog2(SERVE_TICKS + 1);
  localparam int LVL_W = $clog2(LVL_SECS + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  state_t           st_q, st_d;
  logic [DIV_W-1:0] div_q, div_d, period;
  logic [SRV_W-1:0] srv_q, srv_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic             start_q;
  logic             start_rise;
  logic             paused;
  logic             speed_chg;
  logic             step_d, reset_d, dir_d, timer_d, over_d, win_d;
  logic [3:0]       s1_d, s2_d;
  logic [1:0]       speed_d;

`ifdef PONG_SEQ_PAUSE_EN
  assign paused = pause;
`else
  assign paused = 1'b0;
`endif

  assign start_rise = start & ~start_q;
  assign state      = st_q;
  assign period     = DIV_W'(TICK_DIV >> speed_lvl);

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= 4'(WIN_SCORE)) ? v : v + 4'd1;
  endfunction

  // State register plus every registered output and internal counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q       <= IDLE;
      div_q      <= '0;
      srv_q      <= '0;
      lvl_q      <= '0;
      start_q    <= 1'b0;
      ball_step  <= 1'b0;
      ball_reset <= 1'b0;
      serve_dir  <= 1'b0;
      score1     <= '0;
      score2     <= '0;
      speed_lvl  <= '0;
      timer_en   <= 1'b0;
      game_over  <= 1'b0;
      winner     <= 1'b0;
    end else begin
      st_q       <= st_d;
      div_q      <= div_d;
      srv_q      <= srv_d;
      lvl_q      <= lvl_d;
      start_q    <= start;
      ball_step  <= step_d;
      ball_reset <= reset_d;
      serve_dir  <= dir_d;
      score1     <= s1_d;
      score2     <= s2_d;
      speed_lvl  <= speed_d;
      timer_en   <= timer_d;
      game_over  <= over_d;
      winner     <= win_d;
    end
  end

  // Next-state, counter and output computation; outputs are the next-cycle values.
  always_comb begin
    st_d      = st_q;
    div_d     = div_q;
    srv_d     = srv_q;
    lvl_d     = lvl_q;
    step_d    = 1'b0;
    reset_d   = 1'b0;
    dir_d     = serve_dir;
    s1_d      = score1;
    s2_d      = score2;
    speed_d   = speed_lvl;
    win_d     = winner;
    speed_chg = 1'b0;

    unique case (st_q)
      IDLE: begin
        if (start_rise) begin
          st_d    = SERVE;
          div_d   = '0;
          srv_d   = '0;
          reset_d = 1'b1;
        end
      end

      SERVE: begin
        speed_d = '0;
        lvl_d   = '0;
        if (!paused) begin
          if (div_q == DIV_W'(TICK_DIV - 1)) begin
            div_d = '0;
            if (srv_q == SRV_W'(SERVE_TICKS - 1)) begin
              st_d  = PLAY;
              srv_d = '0;
            end else begin
              srv_d = srv_q + 1'b1;
            end
          end else begin
            div_d = div_q + 1'b1;
          end
        end
      end

      PLAY: begin
        if (!paused) begin
          if (sec_tick) begin
            if (lvl_q == LVL_W'(LVL_SECS - 1)) begin
              lvl_d = '0;
              if (speed_lvl != 2'(SPEED_MAX)) begin
                speed_d   = speed_lvl + 2'd1;
                speed_chg = 1'b1;
              end
            end else begin
              lvl_d = lvl_q + 1'b1;
            end
          end
          // A speed-up restarts the cadence instead of producing a wrap step.
          if (speed_chg) begin
            div_d = '0;
          end else if (div_q >= period - DIV_W'(1)) begin
            div_d  = '0;
            step_d = 1'b1;
          end else begin
            div_d = div_q + 1'b1;
          end
        end
        // The step pulse above is kept; the miss only decides the transition.
        if (miss_left || miss_right) begin
          st_d    = POINT;
          reset_d = 1'b1;
          div_d   = '0;
          if (miss_left && miss_right) begin
            dir_d = ~serve_dir;
          end else if (miss_left) begin
            s2_d  = sat_inc(score2);
            dir_d = 1'b1;
          end else begin
            s1_d  = sat_inc(score1);
            dir_d = 1'b0;
          end
        end
      end

      POINT: begin
        if (score1 == 4'(WIN_SCORE) || score2 == 4'(WIN_SCORE)) begin
          st_d  = OVER;
          win_d = (score2 == 4'(WIN_SCORE));
        end else begin
          st_d    = SERVE;
          div_d   = '0;
          srv_d   = '0;
          lvl_d   = '0;
          speed_d = '0;
        end
      end

      OVER: begin
        if (start_rise) begin
          st_d    = SERVE;
          s1_d    = '0;
          s2_d    = '0;
          speed_d = '0;
          win_d   = 1'b0;
          div_d   = '0;
          srv_d   = '0;
          lvl_d   = '0;
          reset_d = 1'b1;
        end
      end

      default: st_d = IDLE;
    endcase

    timer_d = ((st_d == SERVE) || (st_d == PLAY)) && !paused;
    over_d  = (st_d == OVER);
  end

endmodule

// File: doc/pong_game_sequencer.md
Name: pong_game_sequencer

Overview:
- Top-level game controller for the Pong design. Sequences serve, rally, point and game-over phases.
- Issues ball-step and ball-reset strobes to the ball/paddle datapath and gates the match timer.
- Owns both player scores, the serve direction and the rally speed level, which steps up every 10 s of play.
- Sits between the keypad/start inputs, the ball datapath (miss pulses in, step pulses out), the timer (sec_tick in, timer_en out) and the score/dot-matrix display.

Parameters:
- TICK_DIV, 250000: clk cycles per ball step at speed level 0.
- SPEED_MAX, 3: highest speed level. Step period = TICK_DIV >> speed_lvl.
- WIN_SCORE, 5: score that ends the match.
- SERVE_TICKS, 50: level-0 step periods spent in SERVE before play starts.
- LVL_SECS, 10: sec_tick pulses of PLAY per speed-level increment.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- start  in  1  level from push button; rising edge detected internally (previous-sample register)
- sec_tick  in  1  one-cycle pulse per second, clk domain
- miss_left  in  1  one-cycle pulse: ball passed player-1 paddle
- miss_right  in  1  one-cycle pulse: ball passed player-2 paddle
- ball_step  out  1  one-cycle pulse: advance ball one position
- ball_reset  out  1  one-cycle pulse: recentre ball and paddles
- serve_dir  out  1  0 = ball leaves toward player 2, 1 = toward player 1
- score1  out  4  player-1 score
- score2  out  4  player-2 score
- speed_lvl  out  2  current speed level
- timer_en  out  1  high while the match timer may count
- game_over  out  1  high in OVER
- winner  out  1  0 = player 1, 1 = player 2; valid while game_over is high
- state  out  3  IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE; all outputs 0; internal counters 0; start-edge register 0.
  - A reset mid-rally clears everything on that same edge.
- IDLE: on a start rising edge, go to SERVE next cycle and pulse ball_reset for 1 cycle on entry. Scores are already 0.
- SERVE:
  - ball_step held 0; speed_lvl forced to 0; timer_en=1.
  - Counts SERVE_TICKS periods of TICK_DIV cycles, then goes to PLAY.
  - Miss pulses are ignored.
- PLAY:
  - Step divider counts 0..(TICK_DIV>>speed_lvl)-1. ball_step pulses on the cycle the counter wraps.
  - The first pulse occurs exactly TICK_DIV>>speed_lvl cycles after PLAY entry.
  - Each sec_tick increments a level counter. At LVL_SECS it clears and speed_lvl increments, saturating at SPEED_MAX.
  - A speed change restarts the divider at 0 on the same edge.
- Miss handling in PLAY:
  - miss_left alone: score2+1, serve_dir=1, go to POINT next cycle.
  - miss_right alone: score1+1, serve_dir=0, go to POINT next cycle.
  - Both in the same cycle: no score change, serve_dir toggles, go to POINT.
  - The score update and state change happen on the same edge the miss is sampled.
  - A miss coincident with a ball_step cycle: ball_step still pulses that cycle; the miss wins the transition.
- POINT (1 cycle):
  - ball_reset=1, timer_en=0.
  - If score1==WIN_SCORE or score2==WIN_SCORE, go to OVER; else go to SERVE.
- OVER:
  - game_over=1, timer_en=0; winner = the player at WIN_SCORE; scores held.
  - A start rising edge clears scores, speed_lvl and winner, then goes to SERVE with a ball_reset pulse.
- start edges outside IDLE and OVER are ignored.
- Scores never exceed WIN_SCORE. The increment saturates defensively.
- timer_en is 1 in SERVE and PLAY only.
- sec_tick outside PLAY does not advance the level counter.
- All outputs are registered; no combinational path from any input to any output.

Optional Feature:
- Macro: PONG_SEQ_PAUSE_EN.
- Enabled: adds input pause (1 bit, level).
  - While pause==1 in SERVE or PLAY: step divider, serve counter and level counter freeze; ball_step=0; timer_en=0.
  - Miss pulses are still honoured in PLAY.
  - Releasing pause resumes the counts from their frozen values.
- Disabled: no pause port; behaviour exactly as above.

Test Plan:
- Setup for all scenarios: TICK_DIV=8, SERVE_TICKS=2, WIN_SCORE=3, LVL_SECS=2.
- Reset with start=1 held, then release:
  - All outputs are 0 and state=0.
  - A start rising edge gives state=1 and one ball_reset pulse; PLAY is entered 16 cycles later.
- PLAY with no misses: ball_step pulses every 8 cycles. Four sec_tick pulses give speed_lvl=2 and a step period of 2 cycles. Further ticks saturate speed_lvl at 3.
- miss_right in PLAY:
  - Next cycle score1=1, serve_dir=0, state=3, ball_reset=1.
  - Following cycle state=1 and speed_lvl=0.
- miss_left and miss_right in the same cycle: scores unchanged, serve_dir toggles, POINT then SERVE.
- Three miss_left events: score2=3, state=4, game_over=1, winner=1, timer_en=0. A start edge then clears scores and gives state=1.
- rst=0 pulsed mid-PLAY with score1=2: next cycle everything is 0 and state=IDLE. With PONG_SEQ_PAUSE_EN, pause=1 for 20 cycles in PLAY gives no ball_step, and the step cadence resumes from the frozen count.
